// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and sizing for the branch resolve unit and its history table.
package branch_resolve_unit_pkg;

  localparam int unsigned BHT_ENTRIES = 16;
  localparam int unsigned BHT_IDX_W   = 4;
  localparam int unsigned CTR_W       = 2;
  localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
  localparam int unsigned CNT_W       = 16;

  // Redirect controller: one-cycle REDIRECT after a detected mispredict
  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } brs_state_t;

  // Table index taken from the word-aligned PC bits just above the byte offset
  function automatic logic [BHT_IDX_W-1:0] bht_index(input logic [31:0] pc);
    return pc[BHT_IDX_W+1:2];
  endfunction

  // Two-bit saturating counter step: taken counts up, not-taken counts down
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                input logic            taken);
    logic [CTR_W-1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != '1) res = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) res = ctr - CTR_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port (no bypass).
module bht_2bit
  import branch_resolve_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0]     o_rd_ctr,
  input  logic                 i_upd_en,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);

  logic [CTR_W-1:0] r_ctr [BHT_ENTRIES];

  // Counter storage: all entries weakly not-taken on reset, one entry stepped per update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

  // Read port sees the pre-update value when indices collide
  always_comb begin
    o_rd_ctr = r_ctr[i_rd_idx];
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves Execute-stage control flow, trains the
// history table, issues a one-cycle redirect/flush on mispredict and keeps
// saturating branch and mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  output logic             PredictionF,
  input  logic             ValidE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             CondTrueE,
  input  logic             PredictedTakenE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      PCPlus4E,
  output logic             PCSrcE,
  output logic [31:0]      RedirectPCE,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  brs_state_t       r_state;
  brs_state_t       w_next_state;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic             w_idle;
  logic             w_cf;
  logic             w_taken;
  logic             w_mispredict;
  logic             w_upd_en;
  logic [CTR_W-1:0] w_ctr_f;
  logic             w_unused_pc_bits;

  // Only PC[5:2] selects a table entry; the rest of both PCs is irrelevant here
  assign w_unused_pc_bits = ^{PCF[31:BHT_IDX_W+2], PCF[1:0],
                              PCE[31:BHT_IDX_W+2], PCE[1:0]};

  bht_2bit u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (bht_index(PCF)),
    .o_rd_ctr    (w_ctr_f),
    .i_upd_en    (w_upd_en),
    .i_upd_idx   (bht_index(PCE)),
    .i_upd_taken (w_taken)
  );

  // Fetch prediction is the counter's direction bit
  always_comb begin
    PredictionF = w_ctr_f[CTR_W-1];
  end

  // Resolution: Execute inputs are wrong-path while redirecting, so all
  // side effects are gated with IDLE
  always_comb begin
    w_idle       = (r_state == IDLE);
    w_cf         = ValidE & (BranchE | JumpE);
    w_taken      = JumpE | (BranchE & CondTrueE);
    w_mispredict = w_idle & w_cf & (w_taken != PredictedTakenE);
    w_upd_en     = w_idle & ValidE & BranchE;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state: a mispredict opens exactly one REDIRECT cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_mispredict) w_next_state = REDIRECT;
      REDIRECT: w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // FSM outputs: redirect and both flushes are decoded from the state register
  always_comb begin
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (r_state == REDIRECT) begin
      PCSrcE = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Corrected fetch address captured at detection, held until the next mispredict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_pc <= '0;
    end else if (w_mispredict) begin
      r_redirect_pc <= w_taken ? PCTargetE : PCPlus4E;
    end
  end

  assign RedirectPCE = r_redirect_pc;

  // Saturating statistics counters, counting only in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_idle && w_cf && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_mispredict_cnt != '1)) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign BranchCount     = r_branch_cnt;
  assign MispredictCount = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the stimulus process drives one
// cycle at a time and queues the outputs a behavioural model expects for
// that cycle; a monitor on the falling edge pops and compares.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        PredictionF;
  logic        ValidE = 1'b0, BranchE = 1'b0, JumpE = 1'b0;
  logic        CondTrueE = 1'b0, PredictedTakenE = 1'b0;
  logic [31:0] PCE = '0, PCTargetE = '0, PCPlus4E = '0;
  logic        PCSrcE, FlushD, FlushE;
  logic [31:0] RedirectPCE;
  logic [15:0] BranchCount, MispredictCount;

  branch_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .PCF             (PCF),
    .PredictionF     (PredictionF),
    .ValidE          (ValidE),
    .BranchE         (BranchE),
    .JumpE           (JumpE),
    .CondTrueE       (CondTrueE),
    .PredictedTakenE (PredictedTakenE),
    .PCE             (PCE),
    .PCTargetE       (PCTargetE),
    .PCPlus4E        (PCPlus4E),
    .PCSrcE          (PCSrcE),
    .RedirectPCE     (RedirectPCE),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pred;
    logic        pcsrc;
    logic [31:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: counter values as plain integers, a redirect flag
  int          m_ctr[16];
  bit          m_redir;
  int          m_bc, m_mc;
  logic [31:0] m_rpc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_redir = 0;
    m_bc    = 0;
    m_mc    = 0;
    m_rpc   = '0;
  endfunction

  function automatic void model_step(input bit v, b, j, c, pt,
                                     input logic [31:0] pce, tgt, p4);
    bit cf, tk;
    int idx;
    if (m_redir) begin
      m_redir = 0;
      return;
    end
    cf  = v && (b || j);
    tk  = j || (b && c);
    idx = int'(pce[5:2]);
    if (v && b) begin
      if (tk) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
      else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
    end
    if (cf && m_bc < 65535) m_bc++;
    if (cf && (tk != pt)) begin
      if (m_mc < 65535) m_mc++;
      m_redir = 1;
      m_rpc   = tk ? tgt : p4;
    end
  endfunction

  // One cycle of stimulus; queues what the outputs must show during it
  task automatic cyc(input string tag, input bit r, input logic [31:0] pcf,
                     input bit v, b, j, c, pt,
                     input logic [31:0] pce, tgt, p4);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; PCF = pcf; ValidE = v; BranchE = b; JumpE = j;
    CondTrueE = c; PredictedTakenE = pt; PCE = pce; PCTargetE = tgt; PCPlus4E = p4;
    if (r) model_reset();
    e.tag   = tag;
    e.pred  = (m_ctr[int'(pcf[5:2])] >= 2);
    e.pcsrc = m_redir;
    e.rpc   = m_rpc;
    e.bc    = 16'(m_bc);
    e.mc    = 16'(m_mc);
    q.push_back(e);
    if (!r) model_step(v, b, j, c, pt, pce, tgt, p4);
  endtask

  task automatic idle(input string tag, input logic [31:0] pcf);
    cyc(tag, 0, pcf, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%h expected=%h (t=%0t)", tag, what, act, exp, $time);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "PredictionF",     32'(PredictionF),     32'(e.pred));
        chk(e.tag, "PCSrcE",          32'(PCSrcE),          32'(e.pcsrc));
        chk(e.tag, "FlushD",          32'(FlushD),          32'(e.pcsrc));
        chk(e.tag, "FlushE",          32'(FlushE),          32'(e.pcsrc));
        chk(e.tag, "RedirectPCE",     RedirectPCE,          e.rpc);
        chk(e.tag, "BranchCount",     32'(BranchCount),     32'(e.bc));
        chk(e.tag, "MispredictCount", 32'(MispredictCount), 32'(e.mc));
      end
    end
  end

  initial begin
    logic [31:0] pcf, pce;
    bit          v, b, j, c, pt, r;
    model_reset();

    cyc("reset", 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);

    // Not-taken branch predicted not-taken: no redirect, one branch counted
    cyc("nt_ok", 0, 32'h40, 1, 1, 0, 0, 0, 32'h40, 32'h200, 32'h44);
    idle("nt_ok_after", 32'h40);

    // Taken branch predicted not-taken: one-cycle redirect to target
    cyc("tk_miss", 0, 32'h10, 1, 1, 0, 1, 0, 32'h10, 32'h80, 32'h14);
    idle("tk_miss_redir", 32'h10);
    idle("tk_miss_after", 32'h10);

    // Counter training on index 4 from a fresh table: up, saturate, then down
    cyc("train_rst", 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      cyc("train_up", 0, 32'h10, 1, 1, 0, 1, 1, 32'h10, 32'h80, 32'h14);
    for (int k = 0; k < 2; k++)
      cyc("train_dn", 0, 32'h10, 1, 1, 0, 0, 0, 32'h10, 32'h80, 32'h14);
    idle("train_end", 32'h10);

    // Mispredict followed by a wrong-path mispredict on the same index
    cyc("wp_first", 0, 32'h30, 1, 1, 0, 1, 0, 32'h30, 32'h400, 32'h34);
    cyc("wp_second", 0, 32'h30, 1, 1, 0, 1, 0, 32'h30, 32'h500, 32'h34);
    idle("wp_after", 32'h30);
    idle("wp_after2", 32'h30);

    // Jump: redirect without training entry 8
    cyc("jump", 0, 32'h20, 1, 0, 1, 0, 0, 32'h20, 32'h100, 32'h24);
    idle("jump_redir", 32'h20);
    idle("jump_after", 32'h20);

    // Reset arriving during REDIRECT
    cyc("rst_mid_miss", 0, 32'h10, 1, 1, 0, 1, 0, 32'h10, 32'h600, 32'h14);
    cyc("rst_mid", 1, 32'h10, 1, 1, 0, 1, 0, 32'h10, 32'h700, 32'h14);
    idle("rst_mid_after", 32'h10);
    idle("rst_mid_after2", 32'h10);

    // Randomized traffic, biased toward a few indices so counters saturate
    for (int k = 0; k < 2500; k++) begin
      r   = ($urandom_range(0, 299) == 0);
      pcf = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'hFFFF_FFCC);
      pce = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'hFFFF_FFCC);
      v   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 2) != 0);
      j   = ($urandom_range(0, 5) == 0);
      c   = $urandom_range(0, 1) != 0;
      pt  = ($urandom_range(0, 2) == 0);
      cyc("rand", r, pcf, v, b, j, c, pt, pce, $urandom, pce + 32'd4);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 PCF  input  32  fetch-stage PC, used for the prediction lookup.
REQ-004 PredictionF  output  1  predicted-taken bit for PCF, combinational from the table.
REQ-005 ValidE  input  1  Execute-stage instruction is valid (not a bubble).
REQ-006 BranchE  input  1  Execute instruction is a conditional branch.
REQ-007 JumpE  input  1  Execute instruction is an unconditional jump.
REQ-008 CondTrueE  input  1  branch condition evaluated true by the ALU.
REQ-009 PredictedTakenE  input  1  prediction carried down the pipe with this instruction.
REQ-010 PCE  input  32  PC of the Execute instruction.
REQ-011 PCTargetE  input  32  computed taken target.
REQ-012 PCPlus4E  input  32  fall-through address.
REQ-013 PCSrcE  output  1  registered redirect request to fetch.
REQ-014 RedirectPCE  output  32  registered corrected fetch address.
REQ-015 FlushD  output  1  registered flush of the Fetch/Decode register.
REQ-016 FlushE  output  1  registered flush of the Decode/Execute register.
REQ-017 BranchCount  output  16  resolved control-flow instruction count.
REQ-018 MispredictCount  output  16  misprediction count.

Function
REQ-019 Table: 16 x 2-bit saturating counters, index = PC[5:2]; PredictionF = counter[PCF[5:2]] bit 1.
REQ-020 Resolve (combinational, cycle N): CF = ValidE & (BranchE | JumpE); Taken = JumpE | (BranchE & CondTrueE); Mispredict = CF & (Taken != PredictedTakenE).
REQ-021 Counter update at edge ending cycle N when ValidE & BranchE & state IDLE: Taken increments, else decrements; saturates at 2'b11 and 2'b00; jumps do not update the table.
REQ-022 A same-index lookup and update in one cycle returns the pre-update value; there is no bypass.
REQ-023 FSM states: IDLE, REDIRECT.
- IDLE -> REDIRECT on Mispredict.
- REDIRECT -> IDLE unconditionally after one cycle.
REQ-024 In REDIRECT (cycle N+1): PCSrcE = FlushD = FlushE = 1 and RedirectPCE = (Taken ? PCTargetE : PCPlus4E) as captured in cycle N; otherwise all three are 0.
REQ-025 RedirectPCE holds its last value when PCSrcE = 0.
REQ-026 In REDIRECT, Execute inputs are wrong-path: no table update, no counting, no new Mispredict.
REQ-027 BranchCount increments on CF in IDLE; MispredictCount increments on Mispredict in IDLE; both saturate at 16'hFFFF.
REQ-028 Correct prediction: no redirect, no flush, no added latency; redirect latency is exactly one cycle after detection.
REQ-029 ValidE = 0 or CF = 0: no state change apart from the FSM's REDIRECT -> IDLE return.

Reset
REQ-030 rst asserts asynchronously.
- All 16 counters go to 2'b01 (weakly not-taken).
- FSM goes to IDLE.
- PCSrcE, FlushD, FlushE, RedirectPCE, BranchCount and MispredictCount go to 0.
REQ-031 An rst during REDIRECT aborts the redirect; the first cycle after release is IDLE with no flush.

Structure
REQ-032 Shared package holds the FSM state enum, BHT_ENTRIES = 16, BHT_IDX_W = 4, CTR_W = 2, CTR_RESET = 2'b01 and CNT_W = 16.
REQ-033 One sub-module, bht_2bit: the counter array with one combinational read port and one synchronous update port. Resolution logic, FSM and counters stay in branch_resolve_unit.

Verification
REQ-034 After reset, PCF = 0x40 -> PredictionF = 0; CF not-taken branch at PCE = 0x40 predicted 0 -> no PCSrcE, BranchCount = 1, MispredictCount = 0.
REQ-035 Taken branch at PCE = 0x10, PredictedTakenE = 0, PCTargetE = 0x80 -> next cycle PCSrcE = FlushD = FlushE = 1 and RedirectPCE = 0x80 for exactly one cycle; MispredictCount = 1.
REQ-036 Three taken branches at PCE = 0x10 -> counter goes 01 -> 10 -> 11 -> 11, and PredictionF for PCF = 0x10 reads 1 after the first update; then two not-taken -> counter 01, PredictionF = 0.
REQ-037 Mispredicted branch followed next cycle by a ValidE mispredicted branch (wrong path) -> only one REDIRECT cycle, counters unchanged by the second branch.
REQ-038 JumpE at PCE = 0x20, PredictedTakenE = 0, PCTargetE = 0x100 -> redirect to 0x100, table entry 8 unchanged.
REQ-039 rst asserted mid-REDIRECT -> all outputs 0 immediately; after release, no flush and counters read 01.
